// File: rtl/bram_dp_param.sv
// ============================================================================
// Module   : bram_dp_param
// Brief    : True dual-port byte-writable RAM, write-first, port A wins
//            per-lane write collisions, READ_LAT of 1 or 2 with DV strobes.
//            Optional macro BRAM_DP_OOR_ERR_EN enables sticky OOR_ERR flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_dp_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 11,
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  A_EN,
    input  logic [DATA_W/8-1:0]   A_WE,
    input  logic [ADDR_W-1:0]     A_ADDR,
    input  logic [DATA_W-1:0]     A_DI,
    output logic [DATA_W-1:0]     A_DO,
    output logic                  A_DV,
    input  logic                  B_EN,
    input  logic [DATA_W/8-1:0]   B_WE,
    input  logic [ADDR_W-1:0]     B_ADDR,
    input  logic [DATA_W-1:0]     B_DI,
    output logic [DATA_W-1:0]     B_DO,
    output logic                  B_DV,
    output logic [1:0]            OOR_ERR
);

    localparam int NB      = DATA_W / 8;
    localparam int BYTE_SH = (NB > 1) ? $clog2(NB) : 0;
    localparam int IDX_W   = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] a_idx, b_idx;
    logic [IDX_W-1:0]  a_ptr, b_ptr;
    logic              a_inr, b_inr, same_idx;
    logic [NB-1:0]     a_wr, b_wr;
    logic [DATA_W-1:0] a_word, b_word;
    logic [DATA_W-1:0] a_do_d, b_do_d;
    logic [DATA_W-1:0] a_do1_q, b_do1_q;
    logic              a_dv1_q, b_dv1_q;

    assign a_idx    = A_ADDR >> BYTE_SH;
    assign b_idx    = B_ADDR >> BYTE_SH;
    assign a_inr    = (32'(a_idx) < DEPTH);
    assign b_inr    = (32'(b_idx) < DEPTH);
    assign a_ptr    = a_idx[IDX_W-1:0];
    assign b_ptr    = b_idx[IDX_W-1:0];
    assign same_idx = (a_idx == b_idx);
    assign a_wr     = {NB{A_EN & a_inr}} & A_WE;
    assign b_wr     = {NB{B_EN & b_inr}} & B_WE;

    // Port A is written last so it wins any lane both ports enable.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NB; i++) begin
            if (b_wr[i]) mem_q[b_ptr][8*i +: 8] <= B_DI[8*i +: 8];
            if (a_wr[i]) mem_q[a_ptr][8*i +: 8] <= A_DI[8*i +: 8];
        end
    end

    // Write-first read data: same-edge writes from either port bypass the array.
    always_comb begin
        a_word = mem_q[a_ptr];
        b_word = mem_q[b_ptr];
        a_do_d = '0;
        b_do_d = '0;
        for (int i = 0; i < NB; i++) begin
            if (a_wr[i])
                a_do_d[8*i +: 8] = A_DI[8*i +: 8];
            else if (b_wr[i] && same_idx)
                a_do_d[8*i +: 8] = B_DI[8*i +: 8];
            else
                a_do_d[8*i +: 8] = a_word[8*i +: 8];

            if (a_wr[i] && same_idx)
                b_do_d[8*i +: 8] = A_DI[8*i +: 8];
            else if (b_wr[i])
                b_do_d[8*i +: 8] = B_DI[8*i +: 8];
            else
                b_do_d[8*i +: 8] = b_word[8*i +: 8];
        end
        if (!(A_EN && a_inr)) a_do_d = '0;
        if (!(B_EN && b_inr)) b_do_d = '0;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_do1_q <= '0;
            b_do1_q <= '0;
            a_dv1_q <= 1'b0;
            b_dv1_q <= 1'b0;
        end else begin
            a_do1_q <= a_do_d;
            b_do1_q <= b_do_d;
            a_dv1_q <= A_EN;
            b_dv1_q <= B_EN;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign A_DO = a_do1_q;
            assign B_DO = b_do1_q;
            assign A_DV = a_dv1_q;
            assign B_DV = b_dv1_q;
        end else if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] a_do2_q, b_do2_q;
            logic              a_dv2_q, b_dv2_q;
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    a_do2_q <= '0;
                    b_do2_q <= '0;
                    a_dv2_q <= 1'b0;
                    b_dv2_q <= 1'b0;
                end else begin
                    a_do2_q <= a_do1_q;
                    b_do2_q <= b_do1_q;
                    a_dv2_q <= a_dv1_q;
                    b_dv2_q <= b_dv1_q;
                end
            end
            assign A_DO = a_do2_q;
            assign B_DO = b_do2_q;
            assign A_DV = a_dv2_q;
            assign B_DV = b_dv2_q;
        end else begin : g_bad_lat
            $error("bram_dp_param: READ_LAT must be 1 or 2");
        end
    endgenerate

`ifdef BRAM_DP_OOR_ERR_EN
    logic [1:0] oor_q;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) oor_q <= 2'b00;
        else       oor_q <= oor_q | {B_EN & ~b_inr, A_EN & ~a_inr};
    end
    assign OOR_ERR = oor_q;
`else
    assign OOR_ERR = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_dp_param.sv
// ============================================================================
// Module   : tb_bram_dp_param
// Brief    : Scoreboard bench driving a DEPTH=11/LAT=1 and a DEPTH=16/LAT=2
//            instance with identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_dp_param;

    logic        CLK  = 1'b0;
    logic        RSTN = 1'b1;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [3:0]  a_we = '0, b_we = '0;
    logic [11:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_di = '0, b_di = '0;
    logic [31:0] a1_do, b1_do, a2_do, b2_do;
    logic        a1_dv, b1_dv, a2_dv, b2_dv;
    logic [1:0]  oor1, oor2;

    always #5 CLK = ~CLK;

    bram_dp_param #(.DATA_W(32), .DEPTH(11), .ADDR_W(12), .READ_LAT(1)) dut1 (
        .CLK(CLK), .RSTN(RSTN),
        .A_EN(a_en), .A_WE(a_we), .A_ADDR(a_addr), .A_DI(a_di), .A_DO(a1_do), .A_DV(a1_dv),
        .B_EN(b_en), .B_WE(b_we), .B_ADDR(b_addr), .B_DI(b_di), .B_DO(b1_do), .B_DV(b1_dv),
        .OOR_ERR(oor1)
    );

    bram_dp_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(12), .READ_LAT(2)) dut2 (
        .CLK(CLK), .RSTN(RSTN),
        .A_EN(a_en), .A_WE(a_we), .A_ADDR(a_addr), .A_DI(a_di), .A_DO(a2_do), .A_DV(a2_dv),
        .B_EN(b_en), .B_WE(b_we), .B_ADDR(b_addr), .B_DI(b_di), .B_DO(b2_do), .B_DV(b2_dv),
        .OOR_ERR(oor2)
    );

    typedef struct {
        int          port;   // 0=dut1 A, 1=dut1 B, 2=dut2 A, 3=dut2 B
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl [2][16];
    int          depth [2] = '{11, 16};
    int          lat   [2] = '{1, 2};
    logic [1:0]  exp_oor [2] = '{2'b00, 2'b00};

    always @(posedge CLK) cyc <= cyc + 1;

    logic [3:0]  dvs;
    logic [31:0] dos [4];
    always_comb begin
        dvs    = {b2_dv, a2_dv, b1_dv, a1_dv};
        dos[0] = a1_do;
        dos[1] = b1_do;
        dos[2] = a2_do;
        dos[3] = b2_do;
    end

    // Every cycle each port must show exactly the expectation due now, or idle zeros.
    always @(negedge CLK) begin
        if (RSTN) begin
            for (int k = 0; k < 4; k++) begin
                logic        found;
                logic [31:0] ed;
                found = 1'b0;
                ed    = '0;
                foreach (sb[i]) begin
                    if (sb[i].port == k && sb[i].due == cyc) begin
                        found = 1'b1;
                        ed    = sb[i].data;
                    end
                end
                checks++;
                if (dvs[k] !== found || dos[k] !== ed) begin
                    failures++;
                    $display("FAIL rd_port%0d cyc=%0d got dv=%b do=%h expected dv=%b do=%h",
                             k, cyc, dvs[k], dos[k], found, ed);
                end
            end
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].due <= cyc) sb.delete(i);
            checks++;
            if (oor1 !== exp_oor[0]) begin
                failures++;
                $display("FAIL oor_dut1 cyc=%0d got %b expected %b", cyc, oor1, exp_oor[0]);
            end
            checks++;
            if (oor2 !== exp_oor[1]) begin
                failures++;
                $display("FAIL oor_dut2 cyc=%0d got %b expected %b", cyc, oor2, exp_oor[1]);
            end
        end
    end

    task automatic step(input logic ae, input logic [3:0] awe, input logic [11:0] aaddr,
                        input logic [31:0] adi, input logic be, input logic [3:0] bwe,
                        input logic [11:0] baddr, input logic [31:0] bdi);
        logic [1:0] nxt [2];
        a_en = ae; a_we = awe; a_addr = aaddr; a_di = adi;
        b_en = be; b_we = bwe; b_addr = baddr; b_di = bdi;
        for (int d = 0; d < 2; d++) begin
            int ai;
            int bi;
            bit ain;
            bit bin;
            ai  = int'(aaddr >> 2);
            bi  = int'(baddr >> 2);
            ain = (ai < depth[d]);
            bin = (bi < depth[d]);
            if (be && bin)
                for (int l = 0; l < 4; l++)
                    if (bwe[l]) mdl[d][bi][8*l +: 8] = bdi[8*l +: 8];
            if (ae && ain)
                for (int l = 0; l < 4; l++)
                    if (awe[l]) mdl[d][ai][8*l +: 8] = adi[8*l +: 8];
            if (ae) sb.push_back('{2*d,     cyc + lat[d], ain ? mdl[d][ai] : 32'h0});
            if (be) sb.push_back('{2*d + 1, cyc + lat[d], bin ? mdl[d][bi] : 32'h0});
            nxt[d] = exp_oor[d];
`ifdef BRAM_DP_OOR_ERR_EN
            if (ae && !ain) nxt[d][0] = 1'b1;
            if (be && !bin) nxt[d][1] = 1'b1;
`endif
        end
        @(posedge CLK);
        #1;
        exp_oor[0] = nxt[0];
        exp_oor[1] = nxt[1];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 12'h0, 32'h0, 0, 4'h0, 12'h0, 32'h0);
    endtask

    task automatic test_init;
        #1 RSTN = 1'b0;
        #1;
        checks++;
        if ({a1_dv, b1_dv, a2_dv, b2_dv} !== 4'b0 || a1_do !== 0 || b1_do !== 0 ||
            a2_do !== 0 || b2_do !== 0 || oor1 !== 2'b00 || oor2 !== 2'b00) begin
            failures++;
            $display("FAIL reset_state got dv=%b%b%b%b oor=%b/%b expected all zero",
                     a1_dv, b1_dv, a2_dv, b2_dv, oor1, oor2);
        end
        @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < 16; i++) step(1, 4'hF, 12'(i * 4), 32'h0, 0, 4'h0, 12'h0, 32'h0);
        idle(3);
    endtask

    task automatic test_reset;
        step(1, 4'hF, 12'h00C, 32'hDEADBEEF, 0, 4'h0, 12'h0, 32'h0);
        step(1, 4'h0, 12'h00C, 32'h0, 1, 4'h0, 12'h010, 32'h0);
        #1 RSTN = 1'b0;
        sb.delete();
        exp_oor[0] = 2'b00;
        exp_oor[1] = 2'b00;
        #1;
        checks++;
        if ({a1_dv, b1_dv, a2_dv, b2_dv} !== 4'b0 || a1_do !== 0 || b1_do !== 0 ||
            a2_do !== 0 || b2_do !== 0 || oor1 !== 2'b00 || oor2 !== 2'b00) begin
            failures++;
            $display("FAIL async_reset got dv=%b%b%b%b do=%h oor=%b/%b expected all zero",
                     a1_dv, b1_dv, a2_dv, b2_dv, a1_do, oor1, oor2);
        end
        @(posedge CLK);
        @(posedge CLK);
        #1 RSTN = 1'b1;
        idle(3);
        step(1, 4'h0, 12'h00C, 32'h0, 0, 4'h0, 12'h0, 32'h0);
        idle(3);
    endtask

    task automatic test_byte_enables;
        step(1, 4'hF,    12'h008, 32'h11223344, 0, 4'h0, 12'h0, 32'h0);
        step(1, 4'b0101, 12'h008, 32'hAABBCCDD, 0, 4'h0, 12'h0, 32'h0);
        step(1, 4'h0,    12'h008, 32'h0,        0, 4'h0, 12'h0, 32'h0);
        idle(3);
    endtask

    task automatic test_write_first;
        step(1, 4'hF, 12'h014, 32'h00000055, 1, 4'h0, 12'h014, 32'h0);
        step(1, 4'hF, 12'h015, 32'h00000066, 0, 4'h0, 12'h0, 32'h0);
        step(0, 4'h0, 12'h0, 32'h0, 1, 4'b1000, 12'h018, 32'h77000000);
        idle(3);
    endtask

    task automatic test_collision;
        step(1, 4'hF, 12'h008, 32'h0, 0, 4'h0, 12'h0, 32'h0);
        step(1, 4'b0011, 12'h008, 32'hAAAAAAAA, 1, 4'b0110, 12'h008, 32'hBBBBBBBB);
        step(1, 4'h0, 12'h008, 32'h0, 1, 4'h0, 12'h00A, 32'h0);
        idle(3);
    endtask

    task automatic test_out_of_range;
        step(1, 4'hF, 12'h02C, 32'h12345678, 0, 4'h0, 12'h0, 32'h0);
        step(1, 4'h0, 12'h02C, 32'h0, 1, 4'h0, 12'h028, 32'h0);
        idle(2);
        step(0, 4'h0, 12'h0, 32'h0, 1, 4'hF, 12'hFFC, 32'hCAFEF00D);
        idle(3);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) step(0, 4'h0, 12'h0, 32'h0, 1, 4'h0, 12'(i * 4), 32'h0);
        for (int i = 0; i < 8; i++) step(1, 4'h0, 12'(i * 4), 32'h0, 1, 4'h0, 12'(60 - i * 4), 32'h0);
        idle(4);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending reads expected 0", sb.size());
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) mdl[d][w] = 32'h0;
        test_init;
        test_reset;
        test_byte_enables;
        test_write_first;
        test_collision;
        test_out_of_range;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
